// File: rtl/snn_pkg.sv
// Shared definitions for the SNN front end: frame geometry and loader states.
package snn_pkg;

  localparam int N_INPUT       = 784;
  localparam int N_INPUT_BYTES = N_INPUT / 8;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    SHIFT     = 2'd1,
    START     = 2'd2,
    WAIT_CORE = 2'd3
  } loader_state_t;

endpackage

// File: rtl/snn_input_loader_if.sv
// Byte-stream, core-handshake and core read-port signals of the input loader.
interface snn_input_loader_if #(
  parameter int ADDR_W = 10
);

  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic              core_done;
  logic [ADDR_W-1:0] addr_input_unit;
  logic              q_input;
  logic              start;
  logic              busy;
  logic              overrun;

  // Environment side: UART receiver plus SNN core.
  modport master (
    output rx_data, rx_rdy, core_done, addr_input_unit,
    input  q_input, start, busy, overrun
  );

  // Loader side.
  modport slave (
    input  rx_data, rx_rdy, core_done, addr_input_unit,
    output q_input, start, busy, overrun
  );

endinterface

// File: rtl/snn_input_loader_ram.sv
// Single-port 1-bit synchronous RAM holding one input frame; registered read.
module ram_input_unit #(
  parameter int DEPTH  = 784,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  output logic              q
);

  logic mem [DEPTH];

  // Pixel storage: written during unpacking, never reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= data;
  end

  // Registered read so the core sees a one-cycle ROM-like latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= mem[addr];
  end

endmodule

// File: rtl/snn_input_loader.sv
// Unpacks UART bytes LSB-first into the input RAM, launches the core once a
// full frame is stored and holds off further bytes until the core finishes.
module snn_input_loader #(
  parameter int N_INPUT = snn_pkg::N_INPUT,
  parameter int ADDR_W  = 10
) (
  input logic               clk,
  input logic               rst_n,
  snn_input_loader_if.slave bus
);

  import snn_pkg::*;

  // Address of the final pixel; its write completes the frame.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUT - 1);

  loader_state_t     state;
  logic [7:0]        shreg;
  logic [ADDR_W-1:0] wr_ptr;
  logic [2:0]        bit_cnt;
  logic              start_r;
  logic              busy_r;
  logic              overrun_r;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_q;

  // The RAM has one address: unpacking owns it, otherwise the core reads.
  assign ram_we   = (state == SHIFT);
  assign ram_addr = ram_we ? wr_ptr : bus.addr_input_unit;

  ram_input_unit #(
    .DEPTH  (N_INPUT),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (shreg[0]),
    .addr  (ram_addr),
    .we    (ram_we),
    .q     (ram_q)
  );

  assign bus.q_input = ram_q;
  assign bus.start   = start_r;
  assign bus.busy    = busy_r;
  assign bus.overrun = overrun_r;

  // Loader FSM: accept a byte, shift it out bit by bit, hand the frame over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      shreg     <= '0;
      wr_ptr    <= '0;
      bit_cnt   <= '0;
      start_r   <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      start_r <= 1'b0;
      // Any byte outside LOAD is dropped; remember that it happened.
      if (bus.rx_rdy && (state != LOAD)) overrun_r <= 1'b1;
      case (state)
        LOAD: begin
          if (bus.rx_rdy) begin
            shreg   <= bus.rx_data;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg   <= {1'b0, shreg[7:1]};
          wr_ptr  <= wr_ptr + 1'b1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            if (wr_ptr == LAST_ADDR) begin
              state   <= START;
              start_r <= 1'b1;
              busy_r  <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        START: begin
          wr_ptr <= '0;
          state  <= WAIT_CORE;
        end
        WAIT_CORE: begin
          // Clearing wins over a byte dropped on the same cycle.
          if (bus.core_done) begin
            state     <= LOAD;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_input_loader.sv
// Bench for snn_input_loader: frame loads, pixel ordering, drop rule, reset.
module tb_snn_input_loader;

  localparam int N      = 784;
  localparam int NBYTES = 98;

  logic clk;
  logic rst_n;

  snn_input_loader_if #(.ADDR_W(10)) bus ();

  snn_input_loader #(
    .N_INPUT (N),
    .ADDR_W  (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks    = 0;
  int   failures  = 0;
  int   start_cnt = 0;
  logic exp_mem [N];
  logic sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.start === 1'b1) start_cnt++;
  end

  function automatic logic [7:0] byte_of(input int kind, input int k);
    case (kind)
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return (k == 0) ? 8'h80 : 8'h01;
      3:       return (k == 0) ? 8'hAA : 8'(k * 37 + 3);
      default: return 8'(k * 13 + 5);
    endcase
  endfunction

  task automatic model_byte(input int k, input logic [7:0] b);
    for (int j = 0; j < 8; j++) exp_mem[8 * k + j] = b[j];
  endtask

  // Bytes lo..hi of a frame, 20 cycles apart; the 98th byte gets its start
  // pulse timing checked cycle by cycle.
  task automatic send_range(input int kind, input int lo, input int hi);
    logic [7:0] b;
    for (int k = lo; k <= hi; k++) begin
      b = byte_of(kind, k);
      model_byte(k, b);
      @(negedge clk);
      bus.rx_data = b;
      bus.rx_rdy  = 1'b1;
      if (k == NBYTES - 1) begin
        for (int n = 1; n <= 9; n++) begin
          @(negedge clk);
          if (n == 1) bus.rx_rdy = 1'b0;
          check("start_timing", 32'(bus.start), (n == 9) ? 32'd1 : 32'd0);
        end
        check("busy_rise", 32'(bus.busy), 32'd1);
        repeat (3) @(negedge clk);
      end else begin
        @(negedge clk);
        bus.rx_rdy = 1'b0;
        repeat (18) @(negedge clk);
      end
    end
  endtask

  // Sweep the read port; expected pixels queue up as addresses are driven.
  task automatic read_all(input string tag);
    logic e;
    for (int a = 0; a <= N; a++) begin
      @(negedge clk);
      if (a > 0) begin
        if (sb_q.size() == 0) begin
          check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check(tag, 32'(bus.q_input), 32'(e));
        end
      end
      if (a < N) begin
        bus.addr_input_unit = 10'(a);
        sb_q.push_back(exp_mem[a]);
      end
    end
  endtask

  task automatic core_done_pulse();
    @(negedge clk);
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b0;
    check("busy_fall", 32'(bus.busy), 32'd0);
    check("overrun_clear", 32'(bus.overrun), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic full_frame(input int kind, input string tag);
    start_cnt = 0;
    send_range(kind, 0, NBYTES - 1);
    check({tag, "_start_cnt"}, 32'(start_cnt), 32'd1);
    read_all({tag, "_read"});
  endtask

  initial begin
    bus.rx_data         = 8'h00;
    bus.rx_rdy          = 1'b0;
    bus.core_done       = 1'b0;
    bus.addr_input_unit = '0;
    rst_n               = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start", 32'(bus.start), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_q", 32'(bus.q_input), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame of zeros followed directly by a frame of ones.
    full_frame(0, "zeros");
    core_done_pulse();
    full_frame(1, "ones");

    // Byte while the core owns the frame: dropped, flagged, RAM untouched.
    @(negedge clk);
    bus.rx_data = 8'h00;
    bus.rx_rdy  = 1'b1;
    @(negedge clk);
    bus.rx_rdy = 1'b0;
    repeat (12) @(negedge clk);
    check("busy_drop_overrun", 32'(bus.overrun), 32'd1);
    check("busy_drop_busy", 32'(bus.busy), 32'd1);
    read_all("busy_drop_read");
    core_done_pulse();

    // LSB-first ordering.
    full_frame(2, "lsb");
    core_done_pulse();

    // Second byte three cycles into the shift of the first is dropped.
    start_cnt = 0;
    model_byte(0, 8'hAA);
    @(negedge clk);
    bus.rx_data = 8'hAA;
    bus.rx_rdy  = 1'b1;
    @(negedge clk);
    bus.rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
    bus.rx_data = 8'h55;
    bus.rx_rdy  = 1'b1;
    @(negedge clk);
    bus.rx_rdy = 1'b0;
    repeat (15) @(negedge clk);
    check("shift_drop_overrun", 32'(bus.overrun), 32'd1);
    check("shift_drop_busy", 32'(bus.busy), 32'd0);
    send_range(3, 1, NBYTES - 1);
    check("shift_drop_start_cnt", 32'(start_cnt), 32'd1);
    check("shift_drop_overrun_held", 32'(bus.overrun), 32'd1);
    read_all("shift_drop_read");
    core_done_pulse();

    // Reset in the middle of a frame, with overrun set beforehand.
    start_cnt = 0;
    send_range(0, 0, 49);
    @(negedge clk);
    bus.rx_data = 8'h3C;
    bus.rx_rdy  = 1'b1;
    @(negedge clk);
    bus.rx_data = 8'hC3;
    @(negedge clk);
    bus.rx_rdy = 1'b0;
    @(negedge clk);
    check("pre_rst_overrun", 32'(bus.overrun), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_start", 32'(bus.start), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_overrun", 32'(bus.overrun), 32'd0);
    check("midrst_q", 32'(bus.q_input), 32'd0);
    check("midrst_no_start", 32'(start_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    full_frame(4, "after_rst");
    core_done_pulse();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
